rgb_gain_stage: RTL and testbench
=================================

# rgb_gain_stage

Per-channel white-balance gain stage on the 24-bit RGB Avalon-ST video path, placed directly upstream of the colour-detection image processor so that hue/saturation thresholds see balanced colour. Applies programmable 8.8 fixed-point gains with rounding and saturation, passes control packets untouched, and accumulates raw per-channel frame sums that the CPU reads over an MM slave to close an auto-white-balance loop.

## Interface
- GAIN_DEFAULT, 16'h0100, reset value of all three gains (unity, 8.8)
- SUM_W, 32, width of per-channel sum registers (640x480x255 < 2^28)
- CNT_W, 20, width of per-frame pixel counter

- clk  in  1  single clock; everything synchronous to rising edge
- reset  in  1  synchronous, active-high
- s_chipselect / s_read / s_write  in  1 each  MM slave strobes
- s_address  in  3  word address
- s_writedata  in  32  write data
- s_readdata  out  32  registered read data
- sink_data  in  24  {R,G,B}
- sink_valid / sink_sop / sink_eop  in  1 each
- sink_ready  out  1
- source_data  out  24
- source_valid / source_sop / source_eop  out  1 each
- source_ready  in  1

## Operation
- Registers: 0 STATUS (bit0 stats_valid RO, write 1 clears; bit1 bypass RW); 1/2/3 GAIN_R/G/B [15:0] RW; 4/5/6 SUM_R/G/B RO; 7 PIX_COUNT [CNT_W-1:0] RO. Unused bits read 0; writes to RO addresses ignored.
- Word accepted when sink_valid & sink_ready.
- Accepted sop word: header; packet_video <= (sink_data[3:0] == 0). Header always passed unmodified. On video sop: active gains and active bypass loaded from programmed registers; accumulators and pixel counter cleared. Mid-frame register writes take effect at next video sop.
- Non-video packet words: passed unmodified, not accumulated.
- Video non-sop words: accumulators add raw (pre-gain) R, G, B; pixel counter +1. Accepted eop (video): SUM_x and PIX_COUNT latched including that word; stats_valid <= 1.
- stats_valid set and CPU clear in same cycle: set wins.
- Arithmetic per channel: p = c(8) x g(16) -> 24 bits; r = (p + 128) >> 8 (16 bits); out = (r > 255) ? 8'hFF : r[7:0]. Active bypass or non-video/header word: out = in.
- Pipeline: 2 stages, stage 1 registers products and passthrough data/sop/eop/select, stage 2 rounds/saturates into source regs. Global enable en = ~source_valid | source_ready; both stages advance on en; sink_ready = en (combinational).
- Reset: source_valid 0, source_sop/eop 0, source_data 0, stage-1 valid 0, s_readdata 0, gains GAIN_DEFAULT, bypass 0, stats_valid 0, sums/count 0, packet_video 0. Reset mid-frame drops in-flight words; next frame resumes from its sop.

## Timing
- Latency sink accept -> source_valid: 2 cycles with source_ready held high; throughput 1 word/cycle.
- source_ready low: source_data/sop/eop/valid held stable, sink_ready low same cycle; no word lost or duplicated.
- s_readdata valid 1 cycle after s_chipselect & s_read; reads have no side effects.
- SUM/PIX_COUNT visible to reads the cycle after eop acceptance.
- GAIN write visible on readback next cycle; affects pixels only after next video sop.

## Test plan
- Unity gains, video frame of 16 px (header 0x000000, pixels 0x123456 ...) -> identical output stream, 2-cycle latency, SUM_R = sum of R bytes, PIX_COUNT = 16, stats_valid = 1.
- GAIN_R = 0x0200, pixels R = 0x40 and 0x90 -> output R 0x80 and 0xFF (saturated); G/B unchanged.
- GAIN_B = 0x0180, B = 0x01 -> (384+128)>>8 = 0x02; GAIN_G = 0x0000 -> G = 0x00.
- Control packet (header low nibble 0xF) with gains 0x0300 -> all words unmodified, sums unchanged, stats_valid not set.
- Random source_ready toggling across a 640-px line with gain 0x0180 -> output sequence matches model, no drops; write GAIN mid-frame -> takes effect only on next frame.
- Assert reset for 1 cycle mid-frame -> source_valid 0 next cycle, gains 0x0100, stats 0; following complete frame processed correctly.

Source files
------------

// File: rtl/rgb_gain_stage.sv
// rgb_gain_stage
//   Per-channel white-balance gain on a 24-bit {R,G,B} Avalon-ST video path.
//   Video pixels are multiplied by 8.8 fixed-point gains, rounded and
//   saturated to 8 bits. Headers and non-video packets pass through
//   unmodified. Raw (pre-gain) per-channel sums and a pixel count are
//   accumulated per frame and latched at end of frame for the CPU.
//
// Ports
//   clk, reset                  single clock, synchronous active-high reset
//   s_chipselect/read/write     MM slave strobes
//   s_address[2:0]              0 STATUS, 1..3 GAIN_R/G/B, 4..6 SUM_R/G/B,
//                               7 PIX_COUNT
//   s_writedata[31:0]           write data
//   s_readdata[31:0]            registered read data (1 cycle after read)
//   sink_*                      Avalon-ST input  {R,G,B}, sop, eop
//   source_*                    Avalon-ST output {R,G,B}, sop, eop
//
// Handshake: a word transfers on a rising edge where valid and ready are both
// high. The source holds data/sop/eop/valid stable while valid is high and
// ready is low. sink_ready is the shared pipeline enable
// (~source_valid | source_ready), so sink_ready may drop in the same cycle
// source_ready drops, and no word is lost or duplicated.

module rgb_gain_stage #(
  parameter logic [15:0] GAIN_DEFAULT = 16'h0100,
  parameter int          SUM_W        = 32,
  parameter int          CNT_W        = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_chipselect,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [2:0]  s_address,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  input  logic [23:0] sink_data,
  input  logic        sink_valid,
  input  logic        sink_sop,
  input  logic        sink_eop,
  output logic        sink_ready,
  output logic [23:0] source_data,
  output logic        source_valid,
  output logic        source_sop,
  output logic        source_eop,
  input  logic        source_ready
);

  // Programmed registers
  logic [15:0]      r_gain_r, r_gain_g, r_gain_b;
  logic             r_bypass;
  logic             r_stats_valid;
  logic [SUM_W-1:0] r_sum_r, r_sum_g, r_sum_b;
  logic [CNT_W-1:0] r_pix_count;

  // Per-frame working state, captured at each video sop
  logic [15:0]      r_act_gain_r, r_act_gain_g, r_act_gain_b;
  logic             r_act_bypass;
  logic             r_packet_video;
  logic [SUM_W-1:0] r_acc_r, r_acc_g, r_acc_b;
  logic [CNT_W-1:0] r_acc_cnt;

  // Stage 1 registers
  logic             r_s1_valid, r_s1_sop, r_s1_eop, r_s1_gain;
  logic [23:0]      r_s1_data;
  logic [23:0]      r_s1_prod_r, r_s1_prod_g, r_s1_prod_b;

  logic             w_en, w_accept, w_hdr_video, w_video_sop, w_video_px;
  logic             w_latch, w_apply_gain, w_wr, w_rd;
  logic [7:0]       w_r_in, w_g_in, w_b_in;
  logic [SUM_W-1:0] w_acc_r_nxt, w_acc_g_nxt, w_acc_b_nxt;
  logic [CNT_W-1:0] w_acc_cnt_nxt;
  logic [31:0]      w_rdata;
  logic             w_unused_wdata;

  assign w_en       = ~source_valid | source_ready;
  assign sink_ready = w_en;
  assign w_accept   = sink_valid & w_en;

  assign w_r_in = sink_data[23:16];
  assign w_g_in = sink_data[15:8];
  assign w_b_in = sink_data[7:0];

  assign w_hdr_video  = (sink_data[3:0] == 4'h0);
  assign w_video_sop  = w_accept & sink_sop & w_hdr_video;
  assign w_video_px   = w_accept & ~sink_sop & r_packet_video;
  // A video eop latches the stats; a sop+eop video packet latches zeros.
  assign w_latch      = (w_video_sop | w_video_px) & sink_eop;
  assign w_apply_gain = ~sink_sop & r_packet_video & ~r_act_bypass;

  // Accumulator next values include the current word so eop can latch them.
  assign w_acc_r_nxt   = w_video_sop ? '0 : r_acc_r + SUM_W'(w_r_in);
  assign w_acc_g_nxt   = w_video_sop ? '0 : r_acc_g + SUM_W'(w_g_in);
  assign w_acc_b_nxt   = w_video_sop ? '0 : r_acc_b + SUM_W'(w_b_in);
  assign w_acc_cnt_nxt = w_video_sop ? '0 : r_acc_cnt + CNT_W'(1);

  assign w_wr = s_chipselect & s_write;
  assign w_rd = s_chipselect & s_read;
  assign w_unused_wdata = ^s_writedata[31:16];

  // (p + 128) >> 8, clamped to 8 bits
  function automatic logic [7:0] round_sat(input logic [23:0] p);
    logic [15:0] r;
    r = 16'((p + 24'd128) >> 8);
    return (r[15:8] != 8'h00) ? 8'hFF : r[7:0];
  endfunction

  // CPU-programmed registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gain_r <= GAIN_DEFAULT;
      r_gain_g <= GAIN_DEFAULT;
      r_gain_b <= GAIN_DEFAULT;
      r_bypass <= 1'b0;
    end else if (w_wr) begin
      case (s_address)
        3'd0:    r_bypass <= s_writedata[1];
        3'd1:    r_gain_r <= s_writedata[15:0];
        3'd2:    r_gain_g <= s_writedata[15:0];
        3'd3:    r_gain_b <= s_writedata[15:0];
        default: ;
      endcase
    end
  end

  // Frame capture, accumulation and stats latching
  always_ff @(posedge clk) begin
    if (reset) begin
      r_act_gain_r   <= GAIN_DEFAULT;
      r_act_gain_g   <= GAIN_DEFAULT;
      r_act_gain_b   <= GAIN_DEFAULT;
      r_act_bypass   <= 1'b0;
      r_packet_video <= 1'b0;
      r_acc_r        <= '0;
      r_acc_g        <= '0;
      r_acc_b        <= '0;
      r_acc_cnt      <= '0;
      r_sum_r        <= '0;
      r_sum_g        <= '0;
      r_sum_b        <= '0;
      r_pix_count    <= '0;
      r_stats_valid  <= 1'b0;
    end else begin
      if (w_accept && sink_sop) r_packet_video <= w_hdr_video;
      if (w_video_sop) begin
        r_act_gain_r <= r_gain_r;
        r_act_gain_g <= r_gain_g;
        r_act_gain_b <= r_gain_b;
        r_act_bypass <= r_bypass;
      end
      if (w_video_sop || w_video_px) begin
        r_acc_r   <= w_acc_r_nxt;
        r_acc_g   <= w_acc_g_nxt;
        r_acc_b   <= w_acc_b_nxt;
        r_acc_cnt <= w_acc_cnt_nxt;
      end
      if (w_latch) begin
        r_sum_r     <= w_acc_r_nxt;
        r_sum_g     <= w_acc_g_nxt;
        r_sum_b     <= w_acc_b_nxt;
        r_pix_count <= w_acc_cnt_nxt;
      end
      // Hardware set beats a simultaneous CPU clear.
      if (w_latch)
        r_stats_valid <= 1'b1;
      else if (w_wr && s_address == 3'd0 && s_writedata[0])
        r_stats_valid <= 1'b0;
    end
  end

  // Stage 1: products and passthrough
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_sop    <= 1'b0;
      r_s1_eop    <= 1'b0;
      r_s1_gain   <= 1'b0;
      r_s1_data   <= '0;
      r_s1_prod_r <= '0;
      r_s1_prod_g <= '0;
      r_s1_prod_b <= '0;
    end else if (w_en) begin
      r_s1_valid  <= w_accept;
      r_s1_sop    <= w_accept & sink_sop;
      r_s1_eop    <= w_accept & sink_eop;
      r_s1_gain   <= w_apply_gain;
      r_s1_data   <= sink_data;
      r_s1_prod_r <= 24'(w_r_in) * 24'(r_act_gain_r);
      r_s1_prod_g <= 24'(w_g_in) * 24'(r_act_gain_g);
      r_s1_prod_b <= 24'(w_b_in) * 24'(r_act_gain_b);
    end
  end

  // Stage 2: round/saturate into the source registers
  always_ff @(posedge clk) begin
    if (reset) begin
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      source_data  <= '0;
    end else if (w_en) begin
      source_valid <= r_s1_valid;
      source_sop   <= r_s1_sop;
      source_eop   <= r_s1_eop;
      source_data  <= r_s1_gain ? {round_sat(r_s1_prod_r), round_sat(r_s1_prod_g),
                                   round_sat(r_s1_prod_b)}
                                : r_s1_data;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (s_address)
      3'd0: w_rdata = {30'd0, r_bypass, r_stats_valid};
      3'd1: w_rdata = {16'd0, r_gain_r};
      3'd2: w_rdata = {16'd0, r_gain_g};
      3'd3: w_rdata = {16'd0, r_gain_b};
      3'd4: w_rdata = 32'(r_sum_r);
      3'd5: w_rdata = 32'(r_sum_g);
      3'd6: w_rdata = 32'(r_sum_b);
      3'd7: w_rdata = 32'(r_pix_count);
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)     s_readdata <= '0;
    else if (w_rd) s_readdata <= w_rdata;
  end

endmodule

// File: tb/tb_rgb_gain_stage.sv
// Directed testbench for rgb_gain_stage.
module tb_rgb_gain_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_chipselect, s_read, s_write;
  logic [2:0]  s_address;
  logic [31:0] s_writedata, s_readdata;
  logic [23:0] sink_data, source_data;
  logic        sink_valid, sink_sop, sink_eop, sink_ready;
  logic        source_valid, source_sop, source_eop, source_ready;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit rand_ready = 1'b0;

  logic [25:0] exp_q[$];
  logic [25:0] obs_q[$];
  logic        stall_prev = 1'b0;
  logic [26:0] stall_word;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  rgb_gain_stage dut (
    .clk(clk), .reset(reset),
    .s_chipselect(s_chipselect), .s_read(s_read), .s_write(s_write),
    .s_address(s_address), .s_writedata(s_writedata), .s_readdata(s_readdata),
    .sink_data(sink_data), .sink_valid(sink_valid), .sink_sop(sink_sop),
    .sink_eop(sink_eop), .sink_ready(sink_ready),
    .source_data(source_data), .source_valid(source_valid),
    .source_sop(source_sop), .source_eop(source_eop),
    .source_ready(source_ready)
  );

  // Downstream ready: high, or random when rand_ready is set
  initial begin
    source_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      source_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor and stall-stability check, sampled on the falling edge
  initial forever begin
    @(negedge clk);
    if (!reset && source_valid && source_ready)
      obs_q.push_back({source_sop, source_eop, source_data});
    if (stall_prev && !reset) begin
      checks++;
      if ({source_valid, source_sop, source_eop, source_data} !== stall_word) begin
        errors++;
        $display("FAIL stall_hold got %h exp %h",
                 {source_valid, source_sop, source_eop, source_data}, stall_word);
      end
    end
    stall_prev = source_valid && !source_ready && !reset;
    stall_word = {source_valid, source_sop, source_eop, source_data};
  end

  // ---------------- driver tasks ----------------
  task automatic mm_write(input logic [2:0] a, input logic [31:0] d);
    s_chipselect = 1'b1; s_write = 1'b1; s_address = a; s_writedata = d;
    @(posedge clk); #1;
    s_chipselect = 1'b0; s_write = 1'b0;
  endtask

  task automatic mm_read(input logic [2:0] a, output logic [31:0] d);
    s_chipselect = 1'b1; s_read = 1'b1; s_address = a;
    @(posedge clk); #1;
    s_chipselect = 1'b0; s_read = 1'b0;
    d = s_readdata;
  endtask

  task automatic send_word(input logic [23:0] d, input logic s, input logic e);
    logic acc;
    int   n;
    sink_data = d; sink_sop = s; sink_eop = e; sink_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = sink_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 200);
    sink_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL sink_accept_timeout data %h", d);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL drain_timeout got %0d words exp %0d", obs_q.size(), exp_q.size());
    end
  endtask

  function automatic logic [7:0] gmod(input int c, input int g);
    int r;
    r = (c * g + 128) / 256;
    return (r > 255) ? 8'hFF : 8'(r);
  endfunction

  function automatic logic [23:0] upx(input int i);
    return {8'(18 + 3 * i), 8'(52 + 5 * i), 8'(86 + 7 * i)};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] rd;
    logic [31:0] exp_r[8];
    exp_r = '{32'h0, 32'h100, 32'h100, 32'h100, 32'h0, 32'h0, 32'h0, 32'h0};
    checks++;
    if ({source_valid, source_sop, source_eop, source_data, sink_ready} !== {27'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset_outputs got %h exp %h",
               {source_valid, source_sop, source_eop, source_data, sink_ready}, {27'h0, 1'b1});
    end
    for (int a = 0; a < 8; a++) begin
      mm_read(3'(a), rd);
      checks++;
      if (rd !== exp_r[a]) begin
        errors++;
        $display("FAIL reset_reg%0d got %h exp %h", a, rd, exp_r[a]);
      end
    end
  endtask

  task automatic test_unity();
    logic [31:0] rd;
    int t0;
    exp_q.push_back({2'b10, 24'h000000});
    send_word(24'h000000, 1'b1, 1'b0);
    checks++;
    if (source_valid !== 1'b0) begin
      errors++; $display("FAIL latency_early got %b exp 0", source_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({source_valid, source_sop, source_data} !== {2'b11, 24'h0}) begin
      errors++;
      $display("FAIL latency_2cyc got %h exp %h", {source_valid, source_sop, source_data}, {2'b11, 24'h0});
    end
    t0 = cyc;
    for (int i = 0; i < 15; i++) begin
      exp_q.push_back({2'b00, upx(i)});
      send_word(upx(i), 1'b0, 1'b0);
    end
    exp_q.push_back({2'b01, upx(15)});
    // eop acceptance and a CPU stats clear land on the same edge
    fork
      send_word(upx(15), 1'b0, 1'b1);
      mm_write(3'd0, 32'h1);
    join
    checks++;
    if (cyc - t0 !== 16) begin
      errors++; $display("FAIL throughput got %0d cycles exp 16", cyc - t0);
    end
    wait_drain();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL unity_word%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL unity_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    exp_q.delete(); obs_q.delete();
    mm_read(3'd0, rd); checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL unity_stats_setwins got %h exp 1", rd); end
    mm_read(3'd4, rd); checks++;
    if (rd !== 32'd648) begin errors++; $display("FAIL unity_sum_r got %0d exp 648", rd); end
    mm_read(3'd5, rd); checks++;
    if (rd !== 32'd1432) begin errors++; $display("FAIL unity_sum_g got %0d exp 1432", rd); end
    mm_read(3'd6, rd); checks++;
    if (rd !== 32'd2216) begin errors++; $display("FAIL unity_sum_b got %0d exp 2216", rd); end
    mm_read(3'd7, rd); checks++;
    if (rd !== 32'd16) begin errors++; $display("FAIL unity_pix got %0d exp 16", rd); end
    mm_write(3'd0, 32'h1);
    mm_read(3'd0, rd); checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL stats_clear got %h exp 0", rd); end
  endtask

  task automatic test_gain();
    logic [31:0] rd;
    logic [23:0] din[3];
    logic [23:0] dout[3];
    din  = '{24'h407701, 24'h905501, 24'h01FFFF};
    dout = '{24'h800002, 24'hFF0002, 24'h0200FF};
    mm_write(3'd1, 32'h0200);
    mm_write(3'd2, 32'h0000);
    mm_write(3'd3, 32'h0180);
    mm_read(3'd1, rd); checks++;
    if (rd !== 32'h0200) begin errors++; $display("FAIL gain_readback got %h exp 0200", rd); end
    exp_q.push_back({2'b10, 24'h0});
    send_word(24'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b0, i == 2, dout[i]});
      send_word(din[i], 1'b0, i == 2);
    end
    wait_drain();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL gain_word%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL gain_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    exp_q.delete(); obs_q.delete();
    mm_read(3'd4, rd); checks++;
    if (rd !== 32'd209) begin errors++; $display("FAIL gain_sum_r got %0d exp 209", rd); end
    mm_read(3'd5, rd); checks++;
    if (rd !== 32'd459) begin errors++; $display("FAIL gain_sum_g got %0d exp 459", rd); end
    mm_read(3'd7, rd); checks++;
    if (rd !== 32'd3) begin errors++; $display("FAIL gain_pix got %0d exp 3", rd); end
  endtask

  task automatic test_bypass();
    logic [31:0] rd;
    mm_write(3'd0, 32'h2);
    mm_read(3'd0, rd); checks++;
    if (rd !== 32'h3) begin errors++; $display("FAIL bypass_status got %h exp 3", rd); end
    exp_q.push_back({2'b10, 24'h0});      send_word(24'h0, 1'b1, 1'b0);
    exp_q.push_back({2'b00, 24'h407701}); send_word(24'h407701, 1'b0, 1'b0);
    exp_q.push_back({2'b01, 24'h905501}); send_word(24'h905501, 1'b0, 1'b1);
    wait_drain();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bypass_word%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL bypass_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    exp_q.delete(); obs_q.delete();
    mm_read(3'd4, rd); checks++;
    if (rd !== 32'd208) begin errors++; $display("FAIL bypass_sum_r got %0d exp 208", rd); end
    mm_write(3'd0, 32'h1);
    mm_read(3'd0, rd); checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL bypass_clear got %h exp 0", rd); end
  endtask

  task automatic test_control();
    logic [31:0] rd;
    mm_write(3'd1, 32'h0300);
    mm_write(3'd2, 32'h0300);
    mm_write(3'd3, 32'h0300);
    exp_q.push_back({2'b10, 24'h00000F}); send_word(24'h00000F, 1'b1, 1'b0);
    exp_q.push_back({2'b00, 24'h102030}); send_word(24'h102030, 1'b0, 1'b0);
    exp_q.push_back({2'b01, 24'hFFFFFF}); send_word(24'hFFFFFF, 1'b0, 1'b1);
    wait_drain();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL ctrl_word%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL ctrl_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    exp_q.delete(); obs_q.delete();
    mm_read(3'd0, rd); checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL ctrl_stats got %h exp 0", rd); end
    mm_read(3'd4, rd); checks++;
    if (rd !== 32'd208) begin errors++; $display("FAIL ctrl_sum_r got %0d exp 208", rd); end
    mm_read(3'd7, rd); checks++;
    if (rd !== 32'd2) begin errors++; $display("FAIL ctrl_pix got %0d exp 2", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic [23:0] px;
    mm_write(3'd1, 32'h0180);
    mm_write(3'd2, 32'h0180);
    mm_write(3'd3, 32'h0180);
    rand_ready = 1'b1;
    exp_q.push_back({2'b10, 24'h0});
    send_word(24'h0, 1'b1, 1'b0);
    for (int i = 0; i < 640; i++) begin
      px = {8'(i), 8'(3 * i), 8'(255 - i)};
      // Mid-frame gain write must not affect this frame
      if (i == 320) mm_write(3'd1, 32'h0100);
      exp_q.push_back({1'b0, i == 639, gmod(int'(px[23:16]), 384),
                       gmod(int'(px[15:8]), 384), gmod(int'(px[7:0]), 384)});
      send_word(px, 1'b0, i == 639);
    end
    wait_drain();
    mm_read(3'd4, rd); checks++;
    if (rd !== 32'd73408) begin errors++; $display("FAIL line_sum_r got %0d exp 73408", rd); end
    mm_read(3'd7, rd); checks++;
    if (rd !== 32'd640) begin errors++; $display("FAIL line_pix got %0d exp 640", rd); end
    exp_q.push_back({2'b10, 24'h0});
    send_word(24'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      px = {8'(200 + i), 8'(100 + i), 8'(40 * i)};
      exp_q.push_back({1'b0, i == 3, px[23:16], gmod(int'(px[15:8]), 384),
                       gmod(int'(px[7:0]), 384)});
      send_word(px, 1'b0, i == 3);
    end
    wait_drain();
    rand_ready = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL line_word%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL line_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_mid_reset();
    logic [31:0] rd;
    logic [23:0] px[4];
    px = '{24'hABCDEF, 24'h010203, 24'hFF0080, 24'h102030};
    repeat (3) @(posedge clk);
    #1;
    send_word(24'h0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) send_word(upx(i), 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (source_valid !== 1'b0) begin
      errors++; $display("FAIL rst_valid got %b exp 0", source_valid);
    end
    exp_q.delete(); obs_q.delete();
    mm_read(3'd1, rd); checks++;
    if (rd !== 32'h0100) begin errors++; $display("FAIL rst_gain_r got %h exp 0100", rd); end
    mm_read(3'd3, rd); checks++;
    if (rd !== 32'h0100) begin errors++; $display("FAIL rst_gain_b got %h exp 0100", rd); end
    mm_read(3'd0, rd); checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL rst_status got %h exp 0", rd); end
    mm_read(3'd4, rd); checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL rst_sum_r got %h exp 0", rd); end
    exp_q.push_back({2'b10, 24'h0});
    send_word(24'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({1'b0, i == 3, px[i]});
      send_word(px[i], 1'b0, i == 3);
    end
    wait_drain();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rst_word%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL rst_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    exp_q.delete(); obs_q.delete();
    mm_read(3'd4, rd); checks++;
    if (rd !== 32'd443) begin errors++; $display("FAIL rst_frame_sum_r got %0d exp 443", rd); end
    mm_read(3'd7, rd); checks++;
    if (rd !== 32'd4) begin errors++; $display("FAIL rst_frame_pix got %0d exp 4", rd); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    s_chipselect = 1'b0; s_read = 1'b0; s_write = 1'b0;
    s_address = '0; s_writedata = '0;
    sink_data = '0; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_unity();
    test_gain();
    test_bypass();
    test_control();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
